// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - shared LCD timing defaults and types for timing and pattern stages
package lcd_timing_pkg;

    localparam int CNT_W = 11;
    localparam int RGB_W = 24;

    localparam int H_SYNC_DEF  = 41;
    localparam int H_BACK_DEF  = 2;
    localparam int H_DISP_DEF  = 480;
    localparam int H_FRONT_DEF = 2;

    localparam int V_SYNC_DEF  = 10;
    localparam int V_BACK_DEF  = 2;
    localparam int V_DISP_DEF  = 272;
    localparam int V_FRONT_DEF = 2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RGB_W-1:0] rgb_t;

    function automatic int line_total(input int sync_w, input int back_w,
                                      input int disp_w, input int front_w);
        return sync_w + back_w + disp_w + front_w;
    endfunction

    localparam int H_TOTAL = line_total(H_SYNC_DEF, H_BACK_DEF, H_DISP_DEF, H_FRONT_DEF);
    localparam int V_TOTAL = line_total(V_SYNC_DEF, V_BACK_DEF, V_DISP_DEF, V_FRONT_DEF);

endpackage

// File: rtl/lcd_timing_gen_if.sv
// rtl/lcd_timing_gen_if.sv - pixel request bus and panel bus between timing gen and pattern stage
interface lcd_timing_gen_if;
    import lcd_timing_pkg::*;

    rgb_t pixel_data;
    cnt_t pixel_xpos;
    cnt_t pixel_ypos;
    cnt_t h_disp;
    cnt_t v_disp;
    logic data_req;
    logic lcd_hs;
    logic lcd_vs;
    logic lcd_de;
    rgb_t lcd_rgb;
    logic frame_start;

    modport master (
        input  pixel_data,
        output pixel_xpos,
        output pixel_ypos,
        output h_disp,
        output v_disp,
        output data_req,
        output lcd_hs,
        output lcd_vs,
        output lcd_de,
        output lcd_rgb,
        output frame_start
    );

    modport slave (
        output pixel_data,
        input  pixel_xpos,
        input  pixel_ypos,
        input  h_disp,
        input  v_disp,
        input  data_req,
        input  lcd_hs,
        input  lcd_vs,
        input  lcd_de,
        input  lcd_rgb,
        input  frame_start
    );

endinterface

// File: rtl/lcd_sync_counter.sv
// rtl/lcd_sync_counter.sv - enabled wrap counter 0..MAX_VAL with same-cycle wrap flag
module lcd_sync_counter
    import lcd_timing_pkg::*;
#(
    parameter int MAX_VAL = H_TOTAL - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output cnt_t cnt,
    output logic wrap
);

    localparam cnt_t LAST = cnt_t'(MAX_VAL);

    cnt_t cnt_d;
    cnt_t cnt_q;

    // wrap is combinational so a cascaded counter advances on the same edge
    always_comb begin
        wrap  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - RGB panel sync/DE generator; outputs are pure decodes of h/v counters
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_DISP  = H_DISP_DEF,
    parameter int H_FRONT = H_FRONT_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_DISP  = V_DISP_DEF,
    parameter int V_FRONT = V_FRONT_DEF
) (
    input  logic              lcd_pclk,
    input  logic              rst,
    lcd_timing_gen_if.master  lcd
);

    localparam int H_TOT = line_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam int V_TOT = line_total(V_SYNC, V_BACK, V_DISP, V_FRONT);

    localparam cnt_t HS_END    = cnt_t'(H_SYNC);
    localparam cnt_t VS_END    = cnt_t'(V_SYNC);
    localparam cnt_t H_DE_BEG  = cnt_t'(H_SYNC + H_BACK);
    localparam cnt_t H_DE_END  = cnt_t'(H_SYNC + H_BACK + H_DISP);
    localparam cnt_t H_REQ_BEG = cnt_t'(H_SYNC + H_BACK - 1);
    localparam cnt_t H_REQ_END = cnt_t'(H_SYNC + H_BACK + H_DISP - 1);
    localparam cnt_t V_ACT_BEG = cnt_t'(V_SYNC + V_BACK);
    localparam cnt_t V_ACT_END = cnt_t'(V_SYNC + V_BACK + V_DISP);

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_wrap;
    logic v_wrap_unused;

    lcd_sync_counter #(
        .MAX_VAL (H_TOT - 1)
    ) u_h_cnt (
        .clk  (lcd_pclk),
        .rst  (rst),
        .en   (1'b1),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    lcd_sync_counter #(
        .MAX_VAL (V_TOT - 1)
    ) u_v_cnt (
        .clk  (lcd_pclk),
        .rst  (rst),
        .en   (h_wrap),
        .cnt  (v_cnt),
        .wrap (v_wrap_unused)
    );

    logic v_act;
    logic de;
    logic req;

    // data_req leads lcd_de by one pixel so the pattern stage's register lines up
    always_comb begin
        v_act = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        de    = v_act && (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END);
        req   = v_act && (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);

        lcd.h_disp      = cnt_t'(H_DISP);
        lcd.v_disp      = cnt_t'(V_DISP);
        lcd.lcd_hs      = !(h_cnt < HS_END);
        lcd.lcd_vs      = !(v_cnt < VS_END);
        lcd.lcd_de      = de;
        lcd.data_req    = req;
        lcd.pixel_xpos  = '0;
        lcd.pixel_ypos  = '0;
        if (req) begin
            lcd.pixel_xpos = h_cnt - H_REQ_BEG;
            lcd.pixel_ypos = v_cnt - V_ACT_BEG;
        end
        lcd.lcd_rgb     = de ? lcd.pixel_data : '0;
        lcd.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule
